instr_fetch_unit: RTL and testbench

- Multicycle MIPS datapath front end; sits directly upstream of main_controller.
- Holds the program counter (PC), instruction register (IR) and memory data register (MDR).
- Supplies opcode[5:0] to main_controller and the decoded instruction fields to the register file, sign-extend and ALU stages.
- PC/IR updates are driven by control strobes that the control-unit decoder derives from the controller state.

---
 rtl/instr_fetch_unit.sv | 121 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Multicycle MIPS front end: holds PC, IR and MDR, and slices IR into fields for the controller and datapath.
// All state updates land one edge after the strobe; strobes are accepted in any combination, with no handshake or stall.
module instr_fetch_unit #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter int               CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 pc_write,
    input  logic                 pc_write_cond,
    input  logic                 zero,
    input  logic [1:0]           pc_source,
    input  logic [WIDTH-1:0]     alu_result,
    input  logic [WIDTH-1:0]     alu_out,
    input  logic                 ir_write,
    input  logic [WIDTH-1:0]     mem_data,
    output logic [WIDTH-1:0]     pc,
    output logic [WIDTH-1:0]     instr,
    output logic [5:0]           opcode,
    output logic [4:0]           rs,
    output logic [4:0]           rt,
    output logic [4:0]           rd,
    output logic [4:0]           shamt,
    output logic [5:0]           funct,
    output logic [15:0]          imm,
    output logic [WIDTH-1:0]     mdr,
    output logic [CNT_WIDTH-1:0] instr_count,
    output logic                 align_err
);

    logic [WIDTH-1:0]     pc_q, pc_d;
    logic [WIDTH-1:0]     ir_q, ir_d;
    logic [WIDTH-1:0]     mdr_q;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 align_err_q, align_err_d;

    logic                 pc_en;
    logic                 pc_load;
    logic [WIDTH-1:0]     pc_sel;
    logic [WIDTH-1:0]     jump_target;

    // Jump target is built from the pre-edge PC and IR, even when IR reloads on the same edge.
    assign jump_target = {pc_q[WIDTH-1:28], ir_q[25:0], 2'b00};
    assign pc_en       = pc_write | (pc_write_cond & zero);

    always_comb begin
        pc_sel  = pc_q;
        pc_load = 1'b0;
        case (pc_source)
            2'b00: begin
                pc_sel  = alu_result;
                pc_load = pc_en;
            end
            2'b01: begin
                pc_sel  = alu_out;
                pc_load = pc_en;
            end
            2'b10: begin
                pc_sel  = jump_target;
                pc_load = pc_en;
            end
            default: begin
                pc_sel  = pc_q;
                pc_load = 1'b0;
            end
        endcase
    end

    always_comb begin
        pc_d        = pc_q;
        align_err_d = align_err_q;
        if (pc_load) begin
            // Misaligned targets are truncated to a word boundary and flagged until reset.
            pc_d = {pc_sel[WIDTH-1:2], 2'b00};
            if (pc_sel[1:0] != 2'b00) begin
                align_err_d = 1'b1;
            end
        end
    end

    always_comb begin
        ir_d  = ir_q;
        cnt_d = cnt_q;
        if (ir_write) begin
            ir_d  = mem_data;
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            mdr_q       <= '0;
            cnt_q       <= '0;
            align_err_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            mdr_q       <= mem_data;
            cnt_q       <= cnt_d;
            align_err_q <= align_err_d;
        end
    end

    assign pc          = pc_q;
    assign instr       = ir_q;
    assign mdr         = mdr_q;
    assign instr_count = cnt_q;
    assign align_err   = align_err_q;

    assign opcode = ir_q[31:26];
    assign rs     = ir_q[25:21];
    assign rt     = ir_q[20:16];
    assign rd     = ir_q[15:11];
    assign shamt  = ir_q[10:6];
    assign funct  = ir_q[5:0];
    assign imm    = ir_q[15:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vectors plus a short random tail, checked every cycle against a behavioural model.
module tb_instr_fetch_unit;

    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          pc_write, pc_write_cond, zero, ir_write;
    logic [1:0]    pc_source;
    logic [31:0]   alu_result, alu_out, mem_data;
    logic [31:0]   pc, instr, mdr;
    logic [5:0]    opcode, funct;
    logic [4:0]    rs, rt, rd, shamt;
    logic [15:0]   imm;
    logic [CW-1:0] instr_count;
    logic          align_err;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Behavioural model state
    logic [31:0] m_pc, m_ir, m_mdr;
    int          m_cnt;
    logic        m_err;

    instr_fetch_unit #(.WIDTH(32), .RESET_PC(32'h0000_0000), .CNT_WIDTH(CW)) dut (
        .clock(clock), .reset(reset), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .zero(zero), .pc_source(pc_source), .alu_result(alu_result), .alu_out(alu_out),
        .ir_write(ir_write), .mem_data(mem_data), .pc(pc), .instr(instr), .opcode(opcode),
        .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct), .imm(imm), .mdr(mdr),
        .instr_count(instr_count), .align_err(align_err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        logic [31:0] target;
        logic        load;
        if (reset) begin
            m_pc = 32'h0; m_ir = 32'h0; m_mdr = 32'h0; m_cnt = 0; m_err = 1'b0;
        end else begin
            load   = (pc_write || (pc_write_cond && zero)) && (pc_source != 2'd3);
            target = (pc_source == 2'd0) ? alu_result :
                     (pc_source == 2'd1) ? alu_out :
                     (m_pc & 32'hF000_0000) + ((m_ir & 32'h03FF_FFFF) * 4);
            if (load) begin
                if (target % 4 != 0) m_err = 1'b1;
                m_pc = target - (target % 4);
            end
            if (ir_write) begin
                m_ir  = mem_data;
                m_cnt = (m_cnt + 1) % (1 << CW);
            end
            m_mdr = mem_data;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            chk("m.pc",     pc,                 m_pc);
            chk("m.instr",  instr,              m_ir);
            chk("m.mdr",    mdr,                m_mdr);
            chk("m.count",  32'(instr_count),   32'(m_cnt));
            chk("m.err",    32'(align_err),     32'(m_err));
            chk("m.opcode", 32'(opcode),        m_ir / (1 << 26));
            chk("m.rs",     32'(rs),            (m_ir / (1 << 21)) % 32);
            chk("m.rt",     32'(rt),            (m_ir / (1 << 16)) % 32);
            chk("m.rd",     32'(rd),            (m_ir / (1 << 11)) % 32);
            chk("m.shamt",  32'(shamt),         (m_ir / (1 << 6)) % 32);
            chk("m.funct",  32'(funct),         m_ir % 64);
            chk("m.imm",    32'(imm),           m_ir % 65536);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        pc_write = 0; pc_write_cond = 0; zero = 0; ir_write = 0; pc_source = 2'd0;
    endtask

    initial begin
        reset = 1; idle(); alu_result = 0; alu_out = 0; mem_data = 0;
        tick();
        reset = 0; chk_en = 1;
        chk("rst.pc", pc, 32'h0);
        chk("rst.instr", instr, 32'h0);
        chk("rst.opcode", 32'(opcode), 32'h0);
        chk("rst.count", 32'(instr_count), 32'h0);
        chk("rst.err", 32'(align_err), 32'h0);

        // Fetch
        pc_write = 1; ir_write = 1; alu_result = 32'h4; mem_data = 32'h8C22_0004;
        tick(); idle();
        chk("fetch.pc", pc, 32'h4);
        chk("fetch.opcode", 32'(opcode), 32'h23);
        chk("fetch.rs", 32'(rs), 32'h1);
        chk("fetch.rt", 32'(rt), 32'h2);
        chk("fetch.imm", 32'(imm), 32'h4);
        chk("fetch.count", 32'(instr_count), 32'h1);
        tick();
        chk("fetch.mdr", mdr, 32'h8C22_0004);

        // Branch not taken, then taken
        pc_write_cond = 1; pc_source = 2'd1; alu_out = 32'h40; zero = 0;
        tick();
        chk("br.nt.pc", pc, 32'h4);
        zero = 1;
        tick(); idle();
        chk("br.t.pc", pc, 32'h40);

        // Set up PC and IR, then jump while reloading IR
        pc_write = 1; alu_result = 32'h1000_0004; ir_write = 1; mem_data = 32'h0800_0010;
        tick();
        pc_source = 2'd2; mem_data = 32'h0;
        tick(); idle();
        chk("jmp.pc", pc, 32'h1000_0040);
        chk("jmp.instr", instr, 32'h0);
        chk("jmp.count", 32'(instr_count), 32'h3);

        // Reserved select holds PC
        pc_write = 1; pc_source = 2'd3; alu_result = 32'h88;
        tick(); idle();
        chk("rsv.pc", pc, 32'h1000_0040);

        // Misaligned load, then aligned load keeps the flag
        pc_write = 1; alu_result = 32'h6;
        tick();
        chk("mis.pc", pc, 32'h4);
        chk("mis.err", 32'(align_err), 32'h1);
        alu_result = 32'h8;
        tick(); idle();
        chk("mis.pc2", pc, 32'h8);
        chk("mis.sticky", 32'(align_err), 32'h1);

        // Reset wins over strobes
        reset = 1; pc_write = 1; ir_write = 1; alu_result = 32'h100; mem_data = 32'hDEAD_BEEF;
        tick(); reset = 0; idle();
        chk("rp.pc", pc, 32'h0);
        chk("rp.instr", instr, 32'h0);
        chk("rp.count", 32'(instr_count), 32'h0);
        chk("rp.err", 32'(align_err), 32'h0);

        // Counter wrap
        for (int i = 1; i <= 16; i++) begin
            ir_write = 1; mem_data = i * 32'h1111_1111;
            tick();
            if (i == 15) chk("wrap.15", 32'(instr_count), 32'hF);
        end
        idle();
        chk("wrap.0", 32'(instr_count), 32'h0);
        chk("wrap.instr", instr, 32'h1111_1110);

        // Random strobe mix, model-checked each cycle
        for (int i = 0; i < 60; i++) begin
            pc_write      = ($urandom_range(0, 3) == 0);
            pc_write_cond = $urandom_range(0, 1);
            zero          = $urandom_range(0, 1);
            ir_write      = $urandom_range(0, 1);
            pc_source     = 2'($urandom_range(0, 3));
            alu_result    = $urandom;
            alu_out       = $urandom;
            mem_data      = $urandom;
            reset         = ($urandom_range(0, 19) == 0);
            tick();
        end
        reset = 0; idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
